hex_display_driver_de1soc: RTL and testbench
============================================

// Module: hex_display_driver_de1soc
// PURPOSE
//  Multi-digit hex-to-7-segment display driver for the DE1-SoC HEX0..HEXn displays.
//  Accepts an N-digit hex value through a valid/ready handshake and converts it serially,
//  one digit per cycle, through a single glyph decoder. It then commits all digits atomically
//  (no tearing). Adds leading-zero blanking, per-digit blink, global enable and output polarity.
// PARAMETERS
//  NUM_DIGITS  6           number of digits driven (>=1)
//  ACTIVE_LOW  1           1: segment lit = 0 on the pins (DE1-SoC); 0: lit = 1
//  BLINK_DIV   25_000_000  clk cycles per blink half-period (>=1)
// PORTS
//  clk_i          in   1             clock
//  rst_i          in   1             synchronous reset, active high
//  value_i        in   4*NUM_DIGITS  hex value; digit k = value_i[4k+3:4k], digit 0 = rightmost
//  value_valid_i  in   1             value_i/blank_lz_i valid
//  value_ready_o  out  1             driver idle, can accept
//  blank_lz_i     in   1             1: blank leading zero digits (sampled with value)
//  blink_mask_i   in   NUM_DIGITS    1: digit k blinks
//  enable_i       in   1             0: all segments off
//  updated_o      out  1             1-cycle pulse when a new value is committed
//  hex_o          out  7*NUM_DIGITS  digit k at [7k+6:7k], bit order {g,f,e,d,c,b,a}
// BEHAVIOUR
//  Reset (rst_i=1 at clk edge, any state): FSM->IDLE, staged/committed glyphs = blank,
//   blink counter=0, blink phase=ON, updated_o=0, value_ready_o=1 after reset,
//   hex_o = all segments off (all 1s if ACTIVE_LOW, all 0s otherwise). Aborts any conversion.
//  Glyphs (lit=1, {g..a}): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F
//   A:77 b:7C C:39 d:5E E:79 F:71; blank = 00. Output = glyph, inverted if ACTIVE_LOW.
//  FSM: IDLE -> CONVERT -> COMMIT -> IDLE.
//   IDLE: value_ready_o=1; on value_valid_i=1 capture value_i and blank_lz_i, idx=N-1, lead=1.
//   CONVERT: value_ready_o=0; each cycle decode digit idx into staged[idx], idx decrements.
//    lead stays 1 while digits are 0. If blank_lz_i and lead and digit==0 and idx!=0, stage blank.
//    Digit 0 is never blanked. After idx=0, go to COMMIT.
//   COMMIT: committed <= staged (all digits in one edge), updated_o=1 for this cycle,
//    then go to IDLE.
//  Latency: handshake at edge E0; COMMIT edge is E(N+1); hex_o shows new value after
//   edge E(N+2). Throughput: one value per N+2 cycles.
//  value_valid_i while value_ready_o=0 is ignored: no capture, no queueing.
//   value_i changes during CONVERT have no effect.
//  Blink: counter 0..BLINK_DIV-1; on wrap, phase toggles. BLINK_DIV=1 toggles every cycle.
//   Counter runs regardless of FSM state.
//  hex_o is registered every cycle from committed glyphs:
//   digit k off if enable_i=0 or (blink_mask_i[k] and phase=OFF).
//   Changes to enable/blink appear 1 cycle later.
//   Digits blanked by leading-zero rule stay blank regardless of blink.
// TESTING
//  1 Reset, N=6, ACTIVE_LOW=1 -> hex_o = all 7'h7F per digit; value_ready_o=1; updated_o=0.
//  2 value_i=24'h0012AF, blank_lz_i=1, mask=0, enable=1 -> after N+2 cycles:
//     digits5..0 = 7F,7F,79,24,08,0E; updated_o pulses once at COMMIT.
//  3 value_i=24'h000000, blank_lz_i=1 -> only digit0 shows 0 (7'h40), others 7F;
//     with blank_lz_i=0 -> all six 7'h40.
//  4 Hold value_valid_i=1 with new values during CONVERT -> value_ready_o=0, values ignored.
//     The next value is accepted only in IDLE; hex_o never shows a mix of digits.
//  5 BLINK_DIV=4, mask=6'b000001 -> digit0 alternates glyph/7F every 4 cycles, others steady;
//     enable_i=0 -> all 7F after 1 cycle.
//  6 Assert rst_i mid-CONVERT -> next cycle FSM IDLE, hex_o all 7F, no updated_o pulse;
//     next load completes normally.

Source files
------------

// File: rtl/hex_display_driver_de1soc.sv
// Multi-digit hex to 7-segment driver: serial glyph decode, atomic commit.
// Ports: clk_i, rst_i (sync, high), value_i/value_valid_i/value_ready_o
//   handshake, blank_lz_i, blink_mask_i, enable_i, updated_o, hex_o.
module hex_display_driver_de1soc #(
  parameter int NUM_DIGITS = 6,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic                    value_valid_i,
  output logic                    value_ready_o,
  input  logic                    blank_lz_i,
  input  logic [NUM_DIGITS-1:0]   blink_mask_i,
  input  logic                    enable_i,
  output logic                    updated_o,
  output logic [7*NUM_DIGITS-1:0] hex_o
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    COMMIT
  } state_t;

  state_t                  state_q;
  logic [4*NUM_DIGITS-1:0] val_q;
  logic                    blz_q;
  logic [IW-1:0]           idx_q;
  logic                    lead_q;
  logic                    ready_q;
  logic                    upd_q;
  logic [6:0]              staged_q    [NUM_DIGITS];
  logic [6:0]              committed_q [NUM_DIGITS];
  logic [CW-1:0]           cnt_q;
  logic                    phase_on_q;
  logic [7*NUM_DIGITS-1:0] hex_q;

  logic [3:0]              digit;
  logic [6:0]              stage_d;
  logic [6:0]              lit;
  logic [7*NUM_DIGITS-1:0] hex_d;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    unique case (d)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      4'hF: g = 7'h71;
    endcase
    return g;
  endfunction

  // Single shared decoder, fed by the digit currently selected by idx_q.
  always_comb begin
    digit = '0;
    for (int k = 0; k < NUM_DIGITS; k++)
      if (idx_q == IW'(k))
        digit = val_q[4*k +: 4];
    // Digit 0 is never blanked so a zero value still shows "0".
    if (blz_q && lead_q && digit == 4'h0 && idx_q != '0)
      stage_d = '0;
    else
      stage_d = glyph(digit);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      val_q   <= '0;
      blz_q   <= 1'b0;
      idx_q   <= '0;
      lead_q  <= 1'b1;
      ready_q <= 1'b1;
      upd_q   <= 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        staged_q[k]    <= '0;
        committed_q[k] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          upd_q <= 1'b0;
          if (value_valid_i) begin
            val_q   <= value_i;
            blz_q   <= blank_lz_i;
            idx_q   <= IW'(NUM_DIGITS - 1);
            lead_q  <= 1'b1;
            ready_q <= 1'b0;
            state_q <= CONVERT;
          end
        end
        CONVERT: begin
          for (int k = 0; k < NUM_DIGITS; k++)
            if (idx_q == IW'(k))
              staged_q[k] <= stage_d;
          lead_q <= lead_q && (digit == 4'h0);
          if (idx_q == '0) begin
            upd_q   <= 1'b1;
            state_q <= COMMIT;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end
        COMMIT: begin
          for (int k = 0; k < NUM_DIGITS; k++)
            committed_q[k] <= staged_q[k];
          upd_q   <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      phase_on_q <= 1'b1;
    end else if (cnt_q == CW'(BLINK_DIV - 1)) begin
      cnt_q      <= '0;
      phase_on_q <= ~phase_on_q;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    lit   = '0;
    hex_d = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (enable_i && !(blink_mask_i[k] && !phase_on_q))
        lit = committed_q[k];
      else
        lit = '0;
      hex_d[7*k +: 7] = ACTIVE_LOW ? ~lit : lit;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      hex_q <= ACTIVE_LOW ? '1 : '0;
    else
      hex_q <= hex_d;
  end

  assign value_ready_o = ready_q;
  assign updated_o     = upd_q;
  assign hex_o         = hex_q;

endmodule

// File: tb/tb_hex_display_driver_de1soc.sv
// Bench for hex_display_driver_de1soc: scoreboard of committed displays.
// Expected pin images are queued at handshake and checked after commit.
module tb_hex_display_driver_de1soc;

  localparam int N  = 6;
  localparam int W  = 4 * N;
  localparam int HW = 7 * N;
  localparam logic [HW-1:0] ALL_OFF = '1;
  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  value = '0;
  logic          valid = 1'b0;
  logic          blz = 1'b0;
  logic [N-1:0]  mask = '0;
  logic          en = 1'b1;
  logic          ready;
  logic          upd;
  logic [HW-1:0] hex;

  int vectors = 0;
  int miscompares = 0;
  logic [HW-1:0] exp_q[$];
  logic [HW-1:0] shown = ALL_OFF;

  hex_display_driver_de1soc #(
    .NUM_DIGITS(N),
    .ACTIVE_LOW(1'b1),
    .BLINK_DIV(4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .value_i(value),
    .value_valid_i(valid),
    .value_ready_o(ready),
    .blank_lz_i(blz),
    .blink_mask_i(mask),
    .enable_i(en),
    .updated_o(upd),
    .hex_o(hex)
  );

  always #5 clk = ~clk;

  function automatic logic [HW-1:0] model(input logic [W-1:0] v,
                                          input logic lz);
    logic [HW-1:0] r;
    logic          lead;
    logic [3:0]    d;
    r = '0;
    lead = 1'b1;
    for (int k = N - 1; k >= 0; k--) begin
      d = v[4*k +: 4];
      if (lz && lead && d == 4'h0 && k != 0)
        r[7*k +: 7] = 7'h7F;
      else
        r[7*k +: 7] = ~GLYPH[d];
      if (d != 4'h0)
        lead = 1'b0;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] v, input logic lz,
                      input logic [HW-1:0] e);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    vectors++;
    if (ready !== 1'b1) begin
      miscompares++;
      $display("FAIL send_ready: ready=%b required 1", ready);
    end
    value = v;
    blz = lz;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic wait_commit(input string nm);
    int cyc;
    logic [HW-1:0] e;
    cyc = 0;
    do begin
      tick();
      cyc++;
      vectors++;
      if (hex !== shown) begin
        miscompares++;
        $display("FAIL %s_tear: hex=%h required %h", nm, hex, shown);
      end
    end while (upd !== 1'b1 && cyc < 20);
    vectors++;
    if (upd !== 1'b1 || cyc != N) begin
      miscompares++;
      $display("FAIL %s_latency: cycles=%0d upd=%b required %0d 1",
               nm, cyc, upd, N);
    end
    tick();
    vectors++;
    if (upd !== 1'b0 || ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_pulse: upd=%b ready=%b required 0 1",
               nm, upd, ready);
    end
    tick();
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    vectors++;
    if (hex !== e) begin
      miscompares++;
      $display("FAIL %s_hex: hex=%h required %h", nm, hex, e);
    end
    shown = e;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    vectors++;
    if (hex !== ALL_OFF || ready !== 1'b1 || upd !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hold: hex=%h ready=%b upd=%b required %h 1 0",
               hex, ready, upd, ALL_OFF);
    end
    rst = 1'b0;
    tick();
    vectors++;
    if (hex !== ALL_OFF || ready !== 1'b1 || upd !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_after: hex=%h ready=%b upd=%b required %h 1 0",
               hex, ready, upd, ALL_OFF);
    end
  endtask

  task automatic test_lz();
    send(24'h0012AF, 1'b1,
         {7'h7F, 7'h7F, 7'h79, 7'h24, 7'h08, 7'h0E});
    wait_commit("lz_12AF");
    send(24'h123456, 1'b1, model(24'h123456, 1'b1));
    wait_commit("lz_full");
    send(24'h00A000, 1'b1, model(24'h00A000, 1'b1));
    wait_commit("lz_inner");
  endtask

  task automatic test_zero();
    send(24'h000000, 1'b1, {{5{7'h7F}}, 7'h40});
    wait_commit("zero_lz");
    send(24'h000000, 1'b0, {6{7'h40}});
    wait_commit("zero_nolz");
  endtask

  task automatic test_back_to_back();
    logic [HW-1:0] e;
    value = 24'h0BEEF1;
    blz = 1'b1;
    valid = 1'b1;
    tick();
    exp_q.push_back(model(24'h0BEEF1, 1'b1));
    for (int i = 1; i <= N; i++) begin
      value = W'($urandom);
      tick();
      vectors++;
      if (ready !== 1'b0 || hex !== shown ||
          upd !== (i == N)) begin
        miscompares++;
        $display("FAIL b2b_busy%0d: ready=%b upd=%b hex=%h",
                 i, ready, upd, hex);
      end
    end
    value = 24'h00C0DE;
    tick();
    vectors++;
    if (upd !== 1'b0 || ready !== 1'b1 || hex !== shown) begin
      miscompares++;
      $display("FAIL b2b_commit: upd=%b ready=%b hex=%h required 0 1 %h",
               upd, ready, hex, shown);
    end
    tick();
    exp_q.push_back(model(24'h00C0DE, 1'b1));
    valid = 1'b0;
    e = exp_q.pop_front();
    vectors++;
    if (hex !== e) begin
      miscompares++;
      $display("FAIL b2b_first: hex=%h required %h", hex, e);
    end
    shown = e;
    wait_commit("b2b_second");
  endtask

  task automatic test_blink();
    logic [6:0] prev;
    logic [6:0] v;
    logic [6:0] other;
    logic [6:0] expd;
    logic       found;
    send(24'h123455, 1'b0, model(24'h123455, 1'b0));
    wait_commit("blink_load");
    mask = 6'b000001;
    tick();
    prev = hex[6:0];
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      tick();
      if (hex[6:0] !== prev)
        found = 1'b1;
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL blink_toggle: digit0=%h never changed", hex[6:0]);
    end
    v = hex[6:0];
    other = (v === ~GLYPH[5]) ? 7'h7F : ~GLYPH[5];
    vectors++;
    if (v !== ~GLYPH[5] && v !== 7'h7F) begin
      miscompares++;
      $display("FAIL blink_value: digit0=%h required 12 or 7f", v);
    end
    for (int j = 1; j <= 16; j++) begin
      tick();
      expd = (((j / 4) % 2) == 0) ? v : other;
      vectors++;
      if (hex[6:0] !== expd || hex[HW-1:7] !== shown[HW-1:7]) begin
        miscompares++;
        $display("FAIL blink_run%0d: hex=%h required digit0 %h upper %h",
                 j, hex, expd, shown[HW-1:7]);
      end
    end
    mask = '0;
    tick();
    vectors++;
    if (hex !== shown) begin
      miscompares++;
      $display("FAIL blink_off: hex=%h required %h", hex, shown);
    end
    en = 1'b0;
    tick();
    vectors++;
    if (hex !== ALL_OFF) begin
      miscompares++;
      $display("FAIL enable_low: hex=%h required %h", hex, ALL_OFF);
    end
    en = 1'b1;
    tick();
    vectors++;
    if (hex !== shown) begin
      miscompares++;
      $display("FAIL enable_high: hex=%h required %h", hex, shown);
    end
  endtask

  task automatic test_reset_mid();
    send(24'hABCDEF, 1'b0, model(24'hABCDEF, 1'b0));
    tick();
    tick();
    vectors++;
    if (ready !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_busy: ready=%b required 0", ready);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    void'(exp_q.pop_back());
    shown = ALL_OFF;
    vectors++;
    if (ready !== 1'b1 || upd !== 1'b0 || hex !== ALL_OFF) begin
      miscompares++;
      $display("FAIL rstmid_idle: ready=%b upd=%b hex=%h required 1 0 %h",
               ready, upd, hex, ALL_OFF);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if (upd !== 1'b0 || hex !== ALL_OFF) begin
        miscompares++;
        $display("FAIL rstmid_quiet%0d: upd=%b hex=%h required 0 %h",
                 i, upd, hex, ALL_OFF);
      end
    end
    send(24'h654321, 1'b1, model(24'h654321, 1'b1));
    wait_commit("rstmid_reload");
  endtask

  initial begin
    test_reset();
    test_lz();
    test_zero();
    test_back_to_back();
    test_blink();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
